// File: rtl/mandel_pixel_scheduler_if.sv
// Handshake bundle between the pixel scheduler, the iteration core and the VGA adapter.
// The master side is the scheduler; the slave side is its environment (selector, core, VGA).
interface mandel_pixel_scheduler_if;
  logic        go;
  logic [12:0] iter_limit;
  logic        core_start;
  logic [7:0]  core_x;
  logic [6:0]  core_y;
  logic [12:0] core_max;
  logic        core_done;
  logic [12:0] core_count;
  logic        plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  colour;
  logic        busy;
  logic        frame_done;

  modport master (
    input  go, iter_limit, core_done, core_count,
    output core_start, core_x, core_y, core_max,
    output plot, plot_x, plot_y, colour, busy, frame_done
  );

  modport slave (
    output go, iter_limit, core_done, core_count,
    input  core_start, core_x, core_y, core_max,
    input  plot, plot_x, plot_y, colour, busy, frame_done
  );
endinterface

// File: rtl/mandel_pixel_scheduler.sv
// Raster-order frame sequencer: one core launch and one plot strobe per pixel.
// Define MANDEL_AUTO_REDRAW_EN to restart the frame whenever iter_limit changes.
module mandel_pixel_scheduler #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic clock,
  input  logic reset,
  mandel_pixel_scheduler_if.master bus
);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PLOT,
    S_NEXT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [12:0] max_q, max_d;
  logic [2:0]  colour_q, colour_d;
  logic        frame_done_c;
  logic        last_px;
  logic        start_req;
  logic        restart_now;

  // Escaped pixels take the low count bits; black is reserved for points inside the set.
  function automatic logic [2:0] colour_of(input logic [12:0] count, input logic [12:0] limit);
    if (count >= limit)
      return 3'b000;
    else if (count[2:0] == 3'b000)
      return 3'b111;
    else
      return count[2:0];
  endfunction

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef MANDEL_AUTO_REDRAW_EN
  logic restart_q, restart_d;
  logic limit_changed;

  assign limit_changed = (bus.iter_limit != max_q);
  assign start_req     = bus.go | limit_changed;
  assign restart_now   = restart_q | limit_changed;

  // The flag remembers a limit change seen mid-pixel until NEXT can act on it.
  always_comb begin
    restart_d = restart_q;
    if (state_q == S_IDLE || state_q == S_NEXT)
      restart_d = 1'b0;
    else if (limit_changed)
      restart_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      restart_q <= 1'b0;
    else
      restart_q <= restart_d;
  end
`else
  assign start_req   = bus.go;
  assign restart_now = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    max_d        = max_q;
    colour_d     = colour_q;
    frame_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          max_d   = bus.iter_limit;
          x_d     = '0;
          y_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_done) begin
          colour_d = colour_of(bus.core_count, max_q);
          state_d  = S_PLOT;
        end
      end
      S_PLOT: state_d = S_NEXT;
      S_NEXT: begin
        state_d = S_ISSUE;
        if (restart_now) begin
          max_d = bus.iter_limit;
          x_d   = '0;
          y_d   = '0;
        end else if (last_px) begin
          x_d          = '0;
          y_d          = '0;
          state_d      = S_IDLE;
          frame_done_c = 1'b1;
        end else if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      max_q    <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      max_q    <= max_d;
      colour_q <= colour_d;
    end
  end

  assign bus.core_start = (state_q == S_ISSUE);
  assign bus.core_x     = x_q;
  assign bus.core_y     = y_q;
  assign bus.core_max   = max_q;
  assign bus.plot       = (state_q == S_PLOT);
  assign bus.plot_x     = x_q;
  assign bus.plot_y     = y_q;
  assign bus.colour     = colour_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_c;
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Bench for mandel_pixel_scheduler: randomized core responder plus a raster/colour model.
module tb_mandel_pixel_scheduler;
  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mandel_pixel_scheduler_if bus ();

  mandel_pixel_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // model / environment state
  int         colq[$];
  int         script[$];
  int         max_lat = 1;
  bit         spur_en = 1'b0;
  int         exp_max = 0;
  int         iss_n = 0;
  int         plot_n = 0;
  int         plot_total = 0;
  int         fd_cnt = 0;
  int         since_start = 100;
  bit         fd_exp = 1'b0;
  logic [2:0] col_log [4];
  logic [14:0] first_xy = '1;
  logic [14:0] last_xy = '1;
  logic [14:0] wrap_xy = '1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int mcol(input int cnt, input int mx);
    if (cnt >= mx) return 0;
    if (cnt % 8 == 0) return 7;
    return cnt % 8;
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_strobes"}, 32'({bus.core_start, bus.plot, bus.busy, bus.frame_done}), 0);
    chk({tag, "_core_x"}, 32'(bus.core_x), 0);
    chk({tag, "_core_y"}, 32'(bus.core_y), 0);
    chk({tag, "_core_max"}, 32'(bus.core_max), 0);
    chk({tag, "_plot_xy"}, 32'({bus.plot_x, bus.plot_y}), 0);
    chk({tag, "_colour"}, 32'(bus.colour), 0);
  endtask

  // Core model: answers each start after a random number of WAIT cycles.
  initial begin
    int  lat;
    int  cnt;
    bit  pend;
    pend = 1'b0;
    lat = 0;
    cnt = 0;
    bus.core_done = 1'b0;
    bus.core_count = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.core_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          lat--;
          if (lat == 0) begin
            bus.core_done = 1'b1;
            bus.core_count = 13'(cnt);
            colq.push_back(cnt);
            pend = 1'b0;
          end
        end else if (spur_en && $urandom_range(0, 1) == 0) begin
          bus.core_done = 1'b1;
          bus.core_count = 13'($urandom);
        end
        if (bus.core_start) begin
          pend = 1'b1;
          lat = int'($urandom_range(1, max_lat));
          if (script.size() > 0) cnt = script.pop_front();
          else cnt = int'($urandom_range(0, 700));
        end
      end
    end
  end

  // Compare process: raster order, colour rule, pulse spacing and frame end.
  initial begin
    int c;
    forever begin
      @(negedge clock);
      if (reset) begin
        iss_n = 0;
        plot_n = 0;
        plot_total = 0;
        fd_cnt = 0;
        fd_exp = 1'b0;
        since_start = 100;
        colq.delete();
      end else begin
        since_start++;
        if (bus.core_start) begin
          chk("start_x", 32'(bus.core_x), 32'(iss_n % W));
          chk("start_y", 32'(bus.core_y), 32'(iss_n / W));
          chk("start_max", 32'(bus.core_max), 32'(exp_max));
          chk("start_gap_ge4", 32'(since_start >= 4), 1);
          chk("start_busy", 32'(bus.busy), 1);
          if (iss_n == W) wrap_xy = {bus.core_x, bus.core_y};
          iss_n = (iss_n + 1) % NPIX;
          since_start = 0;
        end
        chk("frame_done", 32'(bus.frame_done), 32'(fd_exp));
        if (bus.frame_done) fd_cnt++;
        fd_exp = 1'b0;
        if (bus.plot) begin
          if (colq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL plot_without_done actual=plot at x=%0d y=%0d expected=no plot",
                     bus.plot_x, bus.plot_y);
          end else begin
            c = colq.pop_front();
            chk("plot_x", 32'(bus.plot_x), 32'(plot_n % W));
            chk("plot_y", 32'(bus.plot_y), 32'(plot_n / W));
            chk("plot_colour", 32'(bus.colour), 32'(mcol(c, exp_max)));
          end
          if (plot_total < 4) col_log[plot_total] = bus.colour;
          if (plot_n == 0) first_xy = {bus.plot_x, bus.plot_y};
          if (plot_n == NPIX - 1) begin
            last_xy = {bus.plot_x, bus.plot_y};
            fd_exp = 1'b1;
          end
          plot_n = (plot_n + 1) % NPIX;
          plot_total++;
        end
      end
    end
  end

  initial begin
    int guard;
    bus.go = 1'b0;
    bus.iter_limit = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_zero_outs("reset");
    reset = 1'b0;

    // Pixels 0..837 with slow, random core latency and spurious done pulses.
    script = '{511, 8, 5, 3};
    max_lat = 4;
    spur_en = 1'b1;
    bus.iter_limit = 13'd511;
    exp_max = 511;
    bus.go = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    guard = 0;
    while (iss_n < 20 && guard < 5000) begin
      @(posedge clock);
      guard++;
    end
    bus.iter_limit = 13'd1023;
    guard = 0;
    while (iss_n != 5 * W + 38 && guard < 20000) begin
      @(posedge clock);
      guard++;
    end
    chk("timeout_reach_37_5", 32'(guard < 20000), 1);
    #1;
    chk("wait_busy", 32'(bus.busy), 1);
    chk("wait_core_x_37", 32'(bus.core_x), 37);
    chk("wait_core_y_5", 32'(bus.core_y), 5);
    chk("colour_511_of_511", 32'(col_log[0]), 0);
    chk("colour_8", 32'(col_log[1]), 7);
    chk("colour_5", 32'(col_log[2]), 5);
    chk("colour_3", 32'(col_log[3]), 3);
    #1 reset = 1'b1;
    @(negedge clock);
    chk_zero_outs("midwait_reset");
    reset = 1'b0;
    spur_en = 1'b0;
    max_lat = 1;
    repeat (3) @(negedge clock);
    chk("idle_after_reset_busy", 32'(bus.busy), 0);

    // Full frame, one-cycle core, random counts around the limit.
    bus.iter_limit = 13'd511;
    exp_max = 511;
    bus.go = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    guard = 0;
    while (fd_cnt < 1 && guard < 90000) begin
      @(posedge clock);
      guard++;
    end
    chk("timeout_frame_done", 32'(guard < 90000), 1);
    @(negedge clock);
    chk("busy_after_frame", 32'(bus.busy), 0);
    spur_en = 1'b1;
    repeat (12) @(negedge clock);
    spur_en = 1'b0;
    @(negedge clock);
    chk("idle_spurious_busy", 32'(bus.busy), 0);
    chk("plot_count", 32'(plot_total), 32'(NPIX));
    chk("frame_done_pulses", 32'(fd_cnt), 1);
    chk("first_plot_xy", 32'(first_xy), 32'({8'd0, 7'd0}));
    chk("last_plot_xy", 32'(last_xy), 32'({8'd159, 7'd119}));
    chk("line_wrap_xy", 32'(wrap_xy), 32'({8'd0, 7'd1}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mandel_pixel_scheduler.md
# mandel_pixel_scheduler

Frame-level controller that sequences the Mandelbrot iteration core across every pixel of the display. It latches the user-selected iteration limit at frame start, hands one pixel coordinate at a time to the core with a start/done handshake, converts the returned escape count into a 3-bit colour, and issues one plot strobe per pixel to the VGA adapter. It sits between the iteration-count selector (whose 13-bit limit it consumes), the iteration core, and the VGA adapter.

## Interface
- WIDTH, 160, pixels per line; x counter width is 8.
- HEIGHT, 120, lines per frame; y counter width is 7.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  level; sampled only in IDLE; starts one frame render.
- iter_limit  in  13  iteration limit from the selector.
- core_start  out  1  one-cycle pulse; launches the core on core_x/core_y/core_max.
- core_x  out  8  pixel x for the core.
- core_y  out  7  pixel y for the core.
- core_max  out  13  iteration limit latched for the current frame.
- core_done  in  1  one-cycle pulse from the core; core_count is valid in the same cycle.
- core_count  in  13  escape count.
- plot  out  1  one-cycle write strobe to the VGA adapter.
- plot_x  out  8  plot x coordinate.
- plot_y  out  7  plot y coordinate.
- colour  out  3  plot colour.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel's plot.

## Operation
- States:
  - IDLE: on go=1, latch core_max←iter_limit, x=y=0, go to ISSUE.
  - ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until core_done=1, latch core_count, go to PLOT.
  - PLOT: plot=1 for one cycle with the latched colour, then go to NEXT.
  - NEXT: advance coordinates, then go to ISSUE, or to IDLE with frame_done=1 at frame end.
- Coordinate advance:
  - Raster order; x increments.
  - At x=WIDTH-1: x←0, y←y+1.
  - At x=WIDTH-1 and y=HEIGHT-1: frame ends, x=y=0.
- plot_x/plot_y equal core_x/core_y, held stable from ISSUE through PLOT.
- Colour rule:
  - core_count ≥ core_max → 3'b000.
  - Otherwise core_count[2:0]; a value of 3'b000 is replaced by 3'b111.
  - Comparison is unsigned over 13 bits.
- Ignored inputs:
  - core_done outside WAIT is ignored.
  - go outside IDLE is ignored.
  - iter_limit outside IDLE is ignored unless the macro is enabled.
- Reset:
  - Any state → IDLE.
  - All outputs 0; core_max=0; coordinates 0.
  - Mid-frame reset abandons the frame; no plot or frame_done is issued.

## Timing
- Per-pixel cost: 3 + W cycles, where W ≥ 1 is the number of WAIT cycles up to and including core_done.
- core_start pulses are at least 4 cycles apart.
- Exactly one plot per core_done.
- frame_done asserts in the cycle NEXT is left (for HEIGHT×WIDTH = 19200 pixels); busy drops the cycle after.
- go held high: a new frame starts the cycle after returning to IDLE (IDLE dwell is 1 cycle).

## Configuration
- Macro MANDEL_AUTO_REDRAW_EN.
- Defined:
  - iter_limit is compared with core_max every cycle.
  - Mismatch in IDLE: starts a frame without go.
  - Mismatch while busy: sets a restart flag. The pixel in flight still completes through PLOT. NEXT then relatches core_max, resets x=y=0, returns to ISSUE, and does not pulse frame_done.
- Undefined:
  - iter_limit is sampled only on go in IDLE.
  - No restart logic.

## Test plan
- Reset, go=1 one cycle, iter_limit=511, core returns done 2 cycles after each start with count 3 → 19200 plots, each colour 3'b011; first plot at (0,0), last at (159,119); frame_done single pulse; busy low after.
- Core count 511 with core_max=511 → colour 000; count 8 → colour 111; count 5 → colour 101.
- Spurious core_done during ISSUE/PLOT/IDLE → no extra plot, no state change.
- Assert reset mid-WAIT at pixel (37,5) → all outputs 0 next cycle; subsequent go restarts at (0,0).
- Line wrap: after (159,0) the next core_x/core_y is (0,1).
- With MANDEL_AUTO_REDRAW_EN: change iter_limit 511→1023 during pixel (10,0) → that pixel still plots, next core_start is at (0,0) with core_max=1023, no frame_done; without the macro the change is ignored until the next go.
